stream_packet_demux: RTL and testbench
======================================

Name: stream_packet_demux

Overview:
- Parametrised packet demultiplexer for the narrow-bus receive path (default 2-bit dibit stream from the Ethernet RX side).
- Reassembles each packet into: a tag byte selecting one of NUM_CH payload channels, an ADDR_W-bit start address, then payload bytes.
- Emits one address beat per packet and one data beat per payload byte, with channel index and auto-incremented address.
- Sits between the RX deserialiser and the frame-buffer / audio writers; supersedes the fixed two-channel splitter.

Parameters:
IN_W, 2, input chunk width in bits; must divide 8 (1, 2, 4, 8).
ADDR_W, 24, address field width; must be a multiple of 8.
NUM_CH, 2, number of payload channels; legal tags are 0..NUM_CH-1.
CH_W, $clog2(NUM_CH) (min 1), derived width of the channel index.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
axiiv  in  1  input valid; high for the entire packet, with no gaps; low between packets
axiid  in  IN_W  input chunk; bytes and the address field arrive MSB-first
addr_axiov  out  1  one-cycle pulse; addr is valid
addr  out  ADDR_W  packet start address
data_axiov  out  1  one-cycle pulse per payload byte
data  out  8  payload byte
data_ch  out  CH_W  channel of the current packet
data_addr  out  ADDR_W  start address plus byte index within the packet
pkt_done  out  1  one-cycle pulse; packet ended cleanly
pkt_err  out  1  one-cycle pulse; packet dropped or truncated

Behaviour:
- Reset values: all outputs 0, state Idle, shift register and counters cleared. Reset overrides any in-flight packet; no pulses are emitted for it.
- Derived constant: CPB = 8/IN_W chunks per byte.
- Shifting: each accepted chunk is shifted in as shreg <= {shreg, axiid}. A byte completes on the CPB-th chunk.
- Outputs are registered. A completed byte or address appears one cycle after the cycle its final chunk is accepted.
- FSM states: Idle, RecvTag, RecvAddr, RecvData, Drop.
- Idle: if axiiv=1, accept the chunk as tag chunk 0 and go to RecvTag. If CPB=1, go directly to the tag-decision step.
- RecvTag: on tag completion:
  - tag < NUM_CH: latch it as ch, go to RecvAddr.
  - otherwise: go to Drop.
- RecvAddr: accept ADDR_W/IN_W chunks. On completion, pulse addr_axiov next cycle with the full address, load the data address counter from it, and go to RecvData.
- RecvData: on each completed byte, pulse data_axiov next cycle with data, data_ch=ch and data_addr=counter, then increment the counter. The counter wraps modulo 2^ADDR_W.
- Drop: ignore chunks until axiiv=0.
- Packet end is the cycle where axiiv=0 and state != Idle. One cycle later, pulse exactly one of:
  - pkt_done: state was RecvData with zero partial chunks. This includes zero payload bytes.
  - pkt_err: in all other cases, i.e. ended in RecvTag, RecvAddr or Drop, or with a partial byte pending. The partial byte is discarded and no data beat is emitted.
- Then return to Idle.
- Back-to-back packets: an axiiv rising edge in the cycle right after packet end is legal. Idle accepts it while the pkt_done/pkt_err pulse is being emitted.
- Simultaneous events: the final data beat and pkt_done may never coincide; pkt_done follows the final data beat by at least one cycle.
- Registered data, data_ch, data_addr and addr hold their last values between pulses.

Decomposition:
- Shared package stream_pkg: the FSM state enum, a TAG_W=8 constant and the tag encodings (TAG_PIXEL=0, TAG_AUDIO=1). Top-level frame and audio logic reuse these.
- One natural sub-module, chunk_byte_assembler (IN_W parameter), contains the shift register and chunk counter. It outputs byte_valid, byte and partial. It clears its counter when axiiv=0.

Test Plan:
1. Pixel packet, IN_W=2: tag 0x00, addr 0x000102, bytes 0xA5, 0x3C -> addr_axiov once with 0x000102. Two data beats (0xA5 @ 0x000102 ch0, 0x3C @ 0x000103 ch0), each one cycle after its 4th dibit. pkt_done one cycle after axiiv falls.
2. Audio tag plus illegal tag: tag 0x01 with one byte 0x7F -> data_ch=1. Next packet with tag 0x05 and 3 bytes -> no addr/data beats; pkt_err only.
3. Truncation: tag 0, full address, then 2 dibits of a byte -> addr beat, no data beat, pkt_err. Truncating mid-address -> no addr beat, pkt_err.
4. Wrap and back-to-back: addr 0xFFFFFF with 2 bytes -> data_addr 0xFFFFFF then 0x000000. A second packet starts the cycle after the first ends -> decoded correctly, pulses not merged.
5. Reset mid-packet: assert rst during RecvData -> all outputs 0 next cycle, no pkt_done/pkt_err. A following clean packet decodes normally.
6. Parameter sweep: repeat scenario 1 with IN_W=1, 4 and 8, and with ADDR_W=16, NUM_CH=4 (tag 3 valid, tag 4 error) -> identical byte/address results, with latency scaling by CPB.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the stream receive path.
// Holds the packet demux FSM state encoding, the tag width and the tag
// values that select the pixel (frame buffer) and audio payload channels.
// The frame and audio writers import the same tag constants.
package stream_pkg;

  typedef enum logic [2:0] {
    Idle,
    RecvTag,
    RecvAddr,
    RecvData,
    Drop
  } state_t;

  localparam int TAG_W = 8;

  localparam logic [TAG_W-1:0] TAG_PIXEL = 8'd0;
  localparam logic [TAG_W-1:0] TAG_AUDIO = 8'd1;

  // Index width for n items, never narrower than one bit.
  function automatic int widthMin1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_byte_assembler.sv
// Collects IN_W-bit chunks (MSB-first) into bytes.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   axiiv_i      chunk valid; low clears the chunk counter
//   axiid_i      input chunk
//   byteValid_o  the chunk accepted this cycle completes a byte
//   byte_o       the byte completed this cycle (valid with byteValid_o)
//   partial_o    some chunks of an unfinished byte are held
module chunk_byte_assembler
  import stream_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            axiiv_i,
  input  logic [IN_W-1:0] axiid_i,
  output logic            byteValid_o,
  output logic [7:0]      byte_o,
  output logic            partial_o
);

  localparam int CPB   = 8 / IN_W;
  localparam int CNT_W = widthMin1(CPB);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lastChunk;

  assign lastChunk   = axiiv_i && (cnt_q == CNT_W'(CPB - 1));
  assign byteValid_o = lastChunk;
  assign partial_o   = (cnt_q != '0);

  // Chunk position within the current byte; restarts at every gap in valid.
  always_comb begin
    cnt_d = cnt_q;
    if (!axiiv_i || lastChunk) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only the older chunks of a byte need storing; the final chunk is
  // combined on the fly so the byte is usable in the cycle it completes.
  if (IN_W == 8) begin : gNoShift
    assign byte_o = axiid_i;
  end else begin : gShift
    localparam int SH_W = 8 - IN_W;
    logic [SH_W-1:0] shreg_q;

    assign byte_o = {shreg_q, axiid_i};

    always_ff @(posedge clk) begin
      if (rst) begin
        shreg_q <= '0;
      end else if (axiiv_i) begin
        shreg_q <= SH_W'({shreg_q, axiid_i});
      end
    end
  end

endmodule

// File: rtl/stream_packet_demux.sv
// Packet demultiplexer for the narrow RX stream.
// A packet is a tag byte (channel select), an ADDR_W-bit start address and
// payload bytes, all MSB-first. One address beat is emitted per packet and
// one data beat per payload byte, carrying channel and running address.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   axiiv, axiid          input stream (valid held for the whole packet)
//   addr_axiov, addr      start address pulse / value
//   data_axiov, data      payload byte pulse / value
//   data_ch, data_addr    channel and address of the payload byte
//   pkt_done, pkt_err     end-of-packet status pulses
module stream_packet_demux
  import stream_pkg::*;
#(
  parameter int IN_W   = 2,
  parameter int ADDR_W = 24,
  parameter int NUM_CH = 2,
  parameter int CH_W   = widthMin1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [IN_W-1:0]   axiid,
  output logic              addr_axiov,
  output logic [ADDR_W-1:0] addr,
  output logic              data_axiov,
  output logic [7:0]        data,
  output logic [CH_W-1:0]   data_ch,
  output logic [ADDR_W-1:0] data_addr,
  output logic              pkt_done,
  output logic              pkt_err
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int AB_W       = widthMin1(ADDR_BYTES);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [AB_W-1:0]   addrCnt_q, addrCnt_d;
  logic [ADDR_W-1:0] dataCnt_q, dataCnt_d;

  logic              addrValid_q, addrValid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dataValid_q, dataValid_d;
  logic [7:0]        data_q, data_d;
  logic [CH_W-1:0]   dataCh_q, dataCh_d;
  logic [ADDR_W-1:0] dataAddr_q, dataAddr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              byteValid;
  logic [7:0]        byteVal;
  logic              partial;
  logic              tagOk;
  logic [ADDR_W-1:0] addrFull;

  chunk_byte_assembler #(.IN_W(IN_W)) uAssembler (
    .clk        (clk),
    .rst        (rst),
    .axiiv_i    (axiiv),
    .axiid_i    (axiid),
    .byteValid_o(byteValid),
    .byte_o     (byteVal),
    .partial_o  (partial)
  );

  assign tagOk = 32'(byteVal) < 32'(NUM_CH);

  // The data address counter doubles as the address shift register while
  // the address field is arriving; it is loaded with the full value anyway.
  assign addrFull = ADDR_W'({dataCnt_q, byteVal});

  // Packet FSM and registered output beats.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    addrCnt_d   = addrCnt_q;
    dataCnt_d   = dataCnt_q;
    addrValid_d = 1'b0;
    addr_d      = addr_q;
    dataValid_d = 1'b0;
    data_d      = data_q;
    dataCh_d    = dataCh_q;
    dataAddr_d  = dataAddr_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (state_q != Idle && !axiiv) begin
      // Packet end: only a payload phase on a byte boundary is clean.
      state_d   = Idle;
      addrCnt_d = '0;
      if (state_q == RecvData && !partial) begin
        done_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        // Idle shares the tag decision so a one-chunk tag is handled at once.
        Idle, RecvTag: begin
          if (axiiv) begin
            state_d = RecvTag;
            if (byteValid) begin
              if (tagOk) begin
                ch_d    = CH_W'(byteVal);
                state_d = RecvAddr;
              end else begin
                state_d = Drop;
              end
            end
          end
        end
        RecvAddr: begin
          if (byteValid) begin
            dataCnt_d = addrFull;
            if (addrCnt_q == AB_W'(ADDR_BYTES - 1)) begin
              addrValid_d = 1'b1;
              addr_d      = addrFull;
              addrCnt_d   = '0;
              state_d     = RecvData;
            end else begin
              addrCnt_d = addrCnt_q + 1'b1;
            end
          end
        end
        RecvData: begin
          if (byteValid) begin
            dataValid_d = 1'b1;
            data_d      = byteVal;
            dataCh_d    = ch_q;
            dataAddr_d  = dataCnt_q;
            dataCnt_d   = dataCnt_q + 1'b1;
          end
        end
        Drop: begin
        end
        default: state_d = Idle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= Idle;
      ch_q        <= '0;
      addrCnt_q   <= '0;
      dataCnt_q   <= '0;
      addrValid_q <= 1'b0;
      addr_q      <= '0;
      dataValid_q <= 1'b0;
      data_q      <= '0;
      dataCh_q    <= '0;
      dataAddr_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      addrCnt_q   <= addrCnt_d;
      dataCnt_q   <= dataCnt_d;
      addrValid_q <= addrValid_d;
      addr_q      <= addr_d;
      dataValid_q <= dataValid_d;
      data_q      <= data_d;
      dataCh_q    <= dataCh_d;
      dataAddr_q  <= dataAddr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign addr_axiov = addrValid_q;
  assign addr       = addr_q;
  assign data_axiov = dataValid_q;
  assign data       = data_q;
  assign data_ch    = dataCh_q;
  assign data_addr  = dataAddr_q;
  assign pkt_done   = done_q;
  assign pkt_err    = err_q;

endmodule

// File: tb/tb_stream_packet_demux.sv
// Scoreboard bench for stream_packet_demux.
// Five instances cover IN_W = 2, 1, 4, 8 (24-bit address, 2 channels) and
// IN_W = 2 with a 16-bit address and 4 channels. The driver pushes the
// expected beats (with the cycle they must appear in) while sending a
// packet; a negedge monitor pops and compares every pulse it sees.
module tb_stream_packet_demux;

  typedef struct {
    int          kind;
    int          stamp;
    logic [31:0] v;
    logic [31:0] ch;
    logic [31:0] a;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  vld;
  logic [7:0]  chunk;
  logic [2:0]  sel;

  logic        avA[5], dvA[5], dnA[5], erA[5];
  logic [7:0]  dataA[5];
  logic [23:0] addrA[4], daddrA[4];
  logic        chA[4];
  logic [15:0] addr4, daddr4;
  logic [1:0]  ch4;

  logic        mAv, mDv, mDn, mEr;
  logic [7:0]  mData;
  logic [31:0] mAddr, mDaddr, mCh;

  exp_t        q[$];
  logic [7:0]  pkt[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : gInst
    localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    stream_packet_demux #(.IN_W(W), .ADDR_W(24), .NUM_CH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .axiiv     (vld[g]),
      .axiid     (chunk[W-1:0]),
      .addr_axiov(avA[g]),
      .addr      (addrA[g]),
      .data_axiov(dvA[g]),
      .data      (dataA[g]),
      .data_ch   (chA[g]),
      .data_addr (daddrA[g]),
      .pkt_done  (dnA[g]),
      .pkt_err   (erA[g])
    );
  end

  stream_packet_demux #(.IN_W(2), .ADDR_W(16), .NUM_CH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .axiiv     (vld[4]),
    .axiid     (chunk[1:0]),
    .addr_axiov(avA[4]),
    .addr      (addr4),
    .data_axiov(dvA[4]),
    .data      (dataA[4]),
    .data_ch   (ch4),
    .data_addr (daddr4),
    .pkt_done  (dnA[4]),
    .pkt_err   (erA[4])
  );

  // View of whichever instance is currently being exercised.
  always_comb begin
    mAv   = avA[sel];
    mDv   = dvA[sel];
    mDn   = dnA[sel];
    mEr   = erA[sel];
    mData = dataA[sel];
    if (sel == 3'd4) begin
      mAddr  = 32'(addr4);
      mDaddr = 32'(daddr4);
      mCh    = 32'(ch4);
    end else begin
      mAddr  = 32'(addrA[sel[1:0]]);
      mDaddr = 32'(daddrA[sel[1:0]]);
      mCh    = 32'(chA[sel[1:0]]);
    end
  end

  function automatic int inW(input logic [2:0] i);
    return (i == 3'd1) ? 1 : (i == 3'd2) ? 4 : (i == 3'd3) ? 8 : 2;
  endfunction

  function automatic int addrBytes(input logic [2:0] i);
    return (i == 3'd4) ? 2 : 3;
  endfunction

  function automatic int numCh(input logic [2:0] i);
    return (i == 3'd4) ? 4 : 2;
  endfunction

  function automatic logic [31:0] addrMask(input logic [2:0] i);
    return (i == 3'd4) ? 32'h0000_FFFF : 32'h00FF_FFFF;
  endfunction

  function automatic string kname(input int k);
    case (k)
      0:       return "addr_beat";
      1:       return "data_beat";
      2:       return "pkt_done";
      default: return "pkt_err";
    endcase
  endfunction

  task automatic pushExp(input int kind, input logic [31:0] v, input logic [31:0] ch,
                         input logic [31:0] a, input int stamp);
    exp_t e;
    e.kind  = kind;
    e.v     = v;
    e.ch    = ch;
    e.a     = a;
    e.stamp = stamp;
    q.push_back(e);
  endtask

  task automatic checkOutput(input int kind, input logic [31:0] v, input logic [31:0] ch,
                             input logic [31:0] a);
    exp_t e;
    bit   ok;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_%s got v=%h ch=%0d a=%h at cyc %0d, required no pulse",
               kname(kind), v, ch, a, cyc);
    end else begin
      e  = q.pop_front();
      ok = (e.kind == kind) && (e.stamp == cyc);
      if (kind == 0) ok = ok && (e.v == v);
      if (kind == 1) ok = ok && (e.v == v) && (e.ch == ch) && (e.a == a);
      if (!ok) begin
        errors++;
        $display("[TB] FAIL %s got %s v=%h ch=%0d a=%h at cyc %0d, required %s v=%h ch=%0d a=%h at cyc %0d",
                 kname(e.kind), kname(kind), v, ch, a, cyc,
                 kname(e.kind), e.v, e.ch, e.a, e.stamp);
      end
    end
  endtask

  task automatic checkReset(input string name);
    checks++;
    if ({mAv, mDv, mDn, mEr} != 4'b0 || mAddr != 0 || mData != 0 || mCh != 0 || mDaddr != 0) begin
      errors++;
      $display("[TB] FAIL %s got av=%b dv=%b done=%b err=%b addr=%h data=%h ch=%0d daddr=%h, required all zero",
               name, mAv, mDv, mDn, mEr, mAddr, mData, mCh, mDaddr);
    end
  endtask

  // Monitor: every pulse must match the oldest expected beat; expected beats
  // whose cycle has passed without a pulse are reported as missing.
  always @(negedge clk) begin
    if (mAv) checkOutput(0, mAddr, 32'd0, 32'd0);
    if (mDv) checkOutput(1, 32'(mData), mCh, mDaddr);
    if (mDn) checkOutput(2, 32'd0, 32'd0, 32'd0);
    if (mEr) checkOutput(3, 32'd0, 32'd0, 32'd0);
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL missing_%s got no pulse at cyc %0d, required v=%h ch=%0d a=%h",
               kname(q[0].kind), cyc, q[0].v, q[0].ch, q[0].a);
      void'(q.pop_front());
    end
  end

  // Sends pkt (tag, address bytes, payload) to instance inst, then tail
  // extra chunks of an unfinished byte, then ends the packet (or resets).
  task automatic applyStimulus(input logic [2:0] inst, input int tail, input int gap,
                               input bit rstAtEnd);
    int          w, cpb, ab;
    bit          bad;
    logic [31:0] start;
    w     = inW(inst);
    cpb   = 8 / w;
    ab    = addrBytes(inst);
    bad   = 1'b0;
    start = 32'd0;
    sel   = inst;
    for (int b = 0; b < pkt.size(); b++) begin
      for (int j = 0; j < cpb; j++) begin
        @(negedge clk);
        vld   = 5'b1 << inst;
        chunk = 8'((int'(pkt[b]) >> (8 - w * (j + 1))) & ((1 << w) - 1));
        if (j == cpb - 1) begin
          if (b == 0) begin
            bad = int'(pkt[0]) >= numCh(inst);
          end else if (!bad && b <= ab) begin
            start = (start << 8) | 32'(pkt[b]);
            if (b == ab) pushExp(0, start, 32'd0, 32'd0, cyc + 1);
          end else if (!bad) begin
            pushExp(1, 32'(pkt[b]), 32'(pkt[0]), (start + 32'(b - ab - 1)) & addrMask(inst), cyc + 1);
          end
        end
      end
    end
    for (int t = 0; t < tail; t++) begin
      @(negedge clk);
      vld   = 5'b1 << inst;
      chunk = 8'hFF;
    end
    @(negedge clk);
    vld = 5'b0;
    if (rstAtEnd) begin
      rst = 1'b1;
      @(negedge clk);
      checkReset("reset_mid_packet");
      rst = 1'b0;
    end else begin
      pushExp((!bad && pkt.size() > ab && tail == 0) ? 2 : 3, 32'd0, 32'd0, 32'd0, cyc + 1);
    end
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    vld   = 5'b0;
    chunk = 8'h00;
    sel   = 3'd0;
    repeat (3) @(negedge clk);
    checkReset("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Pixel packet, dibits.
    pkt = {8'h00, 8'h00, 8'h01, 8'h02, 8'hA5, 8'h3C};
    applyStimulus(3'd0, 0, 2, 1'b0);

    // Audio channel, then an illegal tag that must be dropped.
    pkt = {8'h01, 8'h00, 8'h00, 8'h10, 8'h7F};
    applyStimulus(3'd0, 0, 2, 1'b0);
    pkt = {8'h05, 8'h11, 8'h22, 8'h33};
    applyStimulus(3'd0, 0, 2, 1'b0);

    // Truncation inside a payload byte, then inside the address.
    pkt = {8'h00, 8'h00, 8'h00, 8'h20};
    applyStimulus(3'd0, 2, 2, 1'b0);
    pkt = {8'h00, 8'h12, 8'h34};
    applyStimulus(3'd0, 1, 2, 1'b0);

    // Address wrap, followed back-to-back by another packet.
    pkt = {8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h22};
    applyStimulus(3'd0, 0, 0, 1'b0);
    pkt = {8'h01, 8'h00, 8'h00, 8'h05, 8'h99};
    applyStimulus(3'd0, 0, 2, 1'b0);

    // Reset during payload, then a clean packet.
    pkt = {8'h00, 8'h00, 8'h00, 8'h40, 8'hAA, 8'hBB};
    applyStimulus(3'd0, 1, 2, 1'b1);
    pkt = {8'h00, 8'h00, 8'h00, 8'h50, 8'hCC};
    applyStimulus(3'd0, 0, 2, 1'b0);

    // Same pixel packet at IN_W = 1, 4 and 8.
    for (int i = 1; i <= 3; i++) begin
      pkt = {8'h00, 8'h00, 8'h01, 8'h02, 8'hA5, 8'h3C};
      applyStimulus(3'(i), 0, 2, 1'b0);
    end

    // 16-bit address, four channels: tag 3 legal, tag 4 dropped.
    pkt = {8'h03, 8'h01, 8'h02, 8'hA5, 8'h3C};
    applyStimulus(3'd4, 0, 2, 1'b0);
    pkt = {8'h04, 8'h01, 8'h02, 8'hA5};
    applyStimulus(3'd4, 0, 2, 1'b0);

    repeat (6) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d outstanding beats, required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
